// File: rtl/hazard_unit_if.sv
// Hazard controller bus: register addresses and enables in, forward/stall/flush out.
// Purely a bundle of wires; no timing of its own.
// No backpressure; the pipeline samples the controls at its next rising edge.
interface hazard_unit_if;
  logic [3:0] RA1D, RA2D;
  logic [3:0] RA1E, RA2E;
  logic [3:0] A3E, A3M, A3W;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE;
  logic       PCSrcE;
  logic       vOpD, vOpE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD;
  logic       FlushD, FlushE;
  logic       vBusy;

  // Pipeline side: drives the stage addresses and enables, consumes the controls
  modport master (
    output RA1D, RA2D, RA1E, RA2E, A3E, A3M, A3W,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, vOpD, vOpE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, vBusy
  );

  // Hazard unit side
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, A3E, A3M, A3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, vOpD, vOpE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, vBusy
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use / vector stalls, branch flush.
// Outputs are combinational from inputs and the vector busy counter (same cycle).
// Stalls hold Fetch/Decode and bubble Execute; a taken branch overrides every stall.
module hazard_unit #(
  parameter int VLAT = 4,
  parameter int CW   = 3
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hz
);

  localparam logic [CW-1:0] LOAD = CW'(VLAT - 1);

  logic [CW-1:0] cnt;
  logic          busy;
  logic          ld_stall;
  logic          v_stall;

  assign busy = (cnt != '0);

  // Vector occupancy: arm on a vector op entering Execute, then count down to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (hz.vOpE && (cnt == '0)) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Hazard detection and output priority; everything reads zero while in reset
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.vBusy     = 1'b0;
    ld_stall     = hz.MemtoRegE & hz.RegWriteE &
                   ((hz.A3E == hz.RA1D) | (hz.A3E == hz.RA2D));
    v_stall      = hz.vOpD & busy;

    if (!rst) begin
      // Memory stage holds the newer value, so it beats Writeback
      if (hz.RegWriteM && (hz.A3M == hz.RA1E))      hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && (hz.A3W == hz.RA1E)) hz.ForwardAE = 2'b01;

      if (hz.RegWriteM && (hz.A3M == hz.RA2E))      hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && (hz.A3W == hz.RA2E)) hz.ForwardBE = 2'b01;

      hz.vBusy = busy;

      if (hz.PCSrcE) begin
        // Wrong-path instructions in Fetch/Decode are discarded, including a waiting vector op
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (ld_stall || v_stall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic.
// Reference model tracks vector occupancy as an absolute "busy until" cycle number.
// Inputs driven on the falling edge, outputs checked 1 time unit later.
module tb_hazard_unit;
  localparam int VLAT = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_until = -1;

  hazard_unit_if hz ();

  hazard_unit #(.VLAT(VLAT), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_in();
    hz.RA1D = 0; hz.RA2D = 0; hz.RA1E = 0; hz.RA2E = 0;
    hz.A3E = 0; hz.A3M = 0; hz.A3W = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemtoRegE = 0; hz.PCSrcE = 0; hz.vOpD = 0; hz.vOpE = 0;
  endtask

  function automatic logic [1:0] exp_fwd(input logic [3:0] ra);
    if (hz.RegWriteM && hz.A3M == ra) return 2'b10;
    if (hz.RegWriteW && hz.A3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  // Check every output against the model, then advance one clock
  task automatic run_cycle();
    logic       busy, ld, vs;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
    #1;
    busy = !rst && (cyc <= busy_until);
    ld   = hz.MemtoRegE && hz.RegWriteE && (hz.A3E == hz.RA1D || hz.A3E == hz.RA2D);
    vs   = hz.vOpD && busy;
    fa = rst ? 2'b00 : exp_fwd(hz.RA1E);
    fb = rst ? 2'b00 : exp_fwd(hz.RA2E);
    sf = 0; sd = 0; fd = 0; fe = 0;
    if (!rst) begin
      if (hz.PCSrcE) begin fd = 1; fe = 1; end
      else if (ld || vs) begin sf = 1; sd = 1; fe = 1; end
    end
    check("ForwardAE", 8'(hz.ForwardAE), 8'(fa));
    check("ForwardBE", 8'(hz.ForwardBE), 8'(fb));
    check("StallF", 8'(hz.StallF), 8'(sf));
    check("StallD", 8'(hz.StallD), 8'(sd));
    check("FlushD", 8'(hz.FlushD), 8'(fd));
    check("FlushE", 8'(hz.FlushE), 8'(fe));
    check("vBusy", 8'(hz.vBusy), 8'(busy));
    if (!rst && hz.vOpE) check("vop_while_busy", 8'(hz.vBusy), 8'd0);
    @(posedge clk);
    if (rst) busy_until = -1;
    else if (hz.vOpE && !(cyc <= busy_until)) busy_until = cyc + VLAT - 1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    hz.RA1E = 5; hz.A3M = 5; hz.A3W = 5; hz.RegWriteM = 1; hz.RegWriteW = 1; hz.PCSrcE = 1;
    #1;
    check("reset_fwdA", 8'(hz.ForwardAE), 8'd0);
    check("reset_flushD", 8'(hz.FlushD), 8'd0);
    run_cycle();
    run_cycle();
    rst = 1'b0;
    clear_in();

    // Forward priority: Memory over Writeback, then Writeback, then none
    hz.RegWriteM = 1; hz.RegWriteW = 1; hz.A3M = 5; hz.A3W = 5; hz.RA1E = 5; hz.RA2E = 5;
    #1; check("fwd_mem", 8'(hz.ForwardAE), 8'd2);
    run_cycle();
    hz.RegWriteM = 0;
    #1; check("fwd_wb", 8'(hz.ForwardAE), 8'd1);
    run_cycle();
    hz.RA1E = 6;
    #1; check("fwd_none", 8'(hz.ForwardAE), 8'd0);
    run_cycle();
    clear_in();

    // Load-use: one bubble, then load moves to Memory and no stall remains
    hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.A3E = 3; hz.RA2D = 3;
    #1; check("lduse_stall", 8'(hz.StallD), 8'd1);
    run_cycle();
    hz.MemtoRegE = 0; hz.RegWriteE = 0; hz.RegWriteM = 1; hz.A3M = 3;
    #1; check("lduse_release", 8'(hz.StallD), 8'd0);
    run_cycle();
    clear_in();
    hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.A3E = 3; hz.RA2D = 4;
    #1; check("lduse_nomatch", 8'(hz.StallF), 8'd0);
    run_cycle();
    hz.MemtoRegE = 0; hz.RA2D = 3;
    run_cycle();
    hz.MemtoRegE = 1; hz.RegWriteE = 0;
    #1; check("no_regwriteE", 8'(hz.StallF), 8'd0);
    run_cycle();
    clear_in();

    // Vector back-to-back: busy and stalled in cycles 1..3, released in cycle 4
    hz.vOpE = 1; hz.vOpD = 1;
    run_cycle();
    hz.vOpE = 0;
    for (int i = 1; i <= VLAT - 1; i++) begin
      #1; check("vec_busy", 8'(hz.vBusy), 8'd1);
      check("vec_stallD", 8'(hz.StallD), 8'd1);
      run_cycle();
    end
    #1; check("vec_free", 8'(hz.vBusy), 8'd0);
    check("vec_release", 8'(hz.StallD), 8'd0);
    run_cycle();
    clear_in();

    // Branch over a load-use stall
    hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.A3E = 7; hz.RA1D = 7; hz.PCSrcE = 1;
    #1; check("br_flushD", 8'(hz.FlushD), 8'd1);
    check("br_stallF", 8'(hz.StallF), 8'd0);
    run_cycle();
    clear_in();

    // Reset mid-busy: rst at cnt==2 clears everything
    hz.vOpE = 1;
    run_cycle();
    hz.vOpE = 0;
    run_cycle();
    rst = 1; hz.vOpD = 1; hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.PCSrcE = 1;
    #1; check("rst_busy", 8'(hz.vBusy), 8'd0);
    run_cycle();
    run_cycle();
    rst = 0; hz.PCSrcE = 0; hz.MemtoRegE = 0;
    #1; check("post_rst_busy", 8'(hz.vBusy), 8'd0);
    run_cycle();
    clear_in();

    // Randomized traffic with small address space to provoke collisions
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      hz.RA1D = 4'($urandom_range(0, 3)); hz.RA2D = 4'($urandom_range(0, 3));
      hz.RA1E = 4'($urandom_range(0, 3)); hz.RA2E = 4'($urandom_range(0, 3));
      hz.A3E = 4'($urandom_range(0, 3)); hz.A3M = 4'($urandom_range(0, 3));
      hz.A3W = 4'($urandom_range(0, 3));
      hz.RegWriteE = 1'($urandom); hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
      hz.MemtoRegE = 1'($urandom);
      hz.PCSrcE = ($urandom_range(0, 7) == 0);
      hz.vOpD = 1'($urandom);
      hz.vOpE = ($urandom_range(0, 2) == 0) && !(cyc <= busy_until);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
